lane_path_seq: RTL and testbench

//  Sequencer for the vector-unit cross-lane path network. Drives the path-select

---
 rtl/lane_path_seq.sv | 157 +++++++++++++++
 tb/tb_lane_path_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lane_path_seq.sv
// Cross-lane path network step sequencer: tree reduction, plus a single-step rotate
// when LANE_PATH_SEQ_ROTATE_EN is defined (default build: every start is a reduce).
module lane_path_seq #(
   parameter int NUM_LANES = 16,
   parameter int LOG_LANES = $clog2(NUM_LANES)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       I_Start,
   input  logic       I_Mode,
   input  logic [2:0] I_Log_Len,
   input  logic [3:0] I_Rot_Amt,
   input  logic       I_Abort,
   input  logic       I_Issue_Rdy,
   input  logic       I_WB_Valid,
   output logic       O_Req,
   output logic [4:0] O_Sel_Path,
   output logic       O_Busy,
   output logic [2:0] O_Step,
   output logic       O_Done,
   output logic       O_Err
);

   // state | meaning
   // IDLE  | waiting for an accepted start
   // ISSUE | request high, waiting for the exec unit to take the step
   // WAIT  | step issued, waiting for its writeback
   // DONE  | one-cycle completion pulse
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [2:0] MAX_LEN = 3'(LOG_LANES);

   state_t     state_q, state_d;
   logic [4:0] stride_q, stride_d;
   logic       rot_q, rot_d;
   logic       req_q, req_d;
   logic [4:0] sel_q, sel_d;
   logic       busy_q, busy_d;
   logic [2:0] step_q, step_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [2:0] len_c;
   logic       rot_start;
   logic       kill;

`ifdef LANE_PATH_SEQ_ROTATE_EN
   assign rot_start = I_Mode;
`else
   logic unused_mode;
   assign unused_mode = I_Mode;
   assign rot_start   = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      stride_d = stride_q;
      rot_d    = rot_q;
      req_d    = req_q;
      sel_d    = sel_q;
      step_d   = step_q;
      done_d   = 1'b0;
      err_d    = err_q;
      len_c    = (I_Log_Len > MAX_LEN) ? MAX_LEN : I_Log_Len;
      kill     = I_Abort && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (I_Start && !I_Abort) begin
               err_d    = 1'b0;
               step_d   = 3'd0;
               rot_d    = rot_start;
               stride_d = rot_start ? {1'b0, I_Rot_Amt} : 5'(5'd1 << (len_c - 3'd1));
               if ((rot_start && I_Rot_Amt == 4'd0) || (!rot_start && len_c == 3'd0)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ISSUE;
                  req_d   = 1'b1;
                  sel_d   = {1'b1, stride_d[3:0]};
               end
            end
         end
         ISSUE: begin
            if (I_Issue_Rdy) begin
               state_d = WAIT;
               req_d   = 1'b0;
            end
         end
         WAIT: begin
            if (I_WB_Valid) begin
               step_d = step_q + 3'd1;
               if (rot_q || stride_q == 5'd1) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  sel_d   = 5'd0;
               end else begin
                  stride_d = stride_q >> 1;
                  state_d  = ISSUE;
                  req_d    = 1'b1;
                  sel_d    = {1'b1, stride_d[3:0]};
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            sel_d   = 5'd0;
         end
         default: state_d = IDLE;
      endcase

      // A writeback the sequencer is not waiting for is a protocol error, unless an abort swallows it.
      if (I_WB_Valid && state_q != WAIT && !kill) err_d = 1'b1;

      if (kill) begin
         state_d  = IDLE;
         req_d    = 1'b0;
         sel_d    = 5'd0;
         done_d   = 1'b0;
         step_d   = step_q;
         stride_d = stride_q;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         stride_q <= 5'd0;
         rot_q    <= 1'b0;
         req_q    <= 1'b0;
         sel_q    <= 5'd0;
         busy_q   <= 1'b0;
         step_q   <= 3'd0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         stride_q <= stride_d;
         rot_q    <= rot_d;
         req_q    <= req_d;
         sel_q    <= sel_d;
         busy_q   <= busy_d;
         step_q   <= step_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign O_Req      = req_q;
   assign O_Sel_Path = sel_q;
   assign O_Busy     = busy_q;
   assign O_Step     = step_q;
   assign O_Done     = done_q;
   assign O_Err      = err_q;

endmodule

// File: tb/tb_lane_path_seq.sv
// Scoreboard bench for lane_path_seq: expected issues/completions are queued at start
// and retired by a negedge monitor as the DUT raises O_Req or O_Done.
module tb_lane_path_seq;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       I_Start = 1'b0;
   logic       I_Mode = 1'b0;
   logic [2:0] I_Log_Len = 3'd0;
   logic [3:0] I_Rot_Amt = 4'd0;
   logic       I_Abort = 1'b0;
   logic       I_Issue_Rdy = 1'b0;
   logic       I_WB_Valid;
   logic       O_Req;
   logic [4:0] O_Sel_Path;
   logic       O_Busy;
   logic [2:0] O_Step;
   logic       O_Done;
   logic       O_Err;

   logic wb_man = 1'b0;
   logic wb_auto_val = 1'b0;
   logic auto_wb = 1'b0;
   logic req_prev = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   start_cyc = 0;

   typedef struct {
      bit is_done;
      int sel;
      int step;
      int cyc;
   } exp_t;
   exp_t sb[$];

   lane_path_seq dut (
      .clock(clock), .reset(reset), .I_Start(I_Start), .I_Mode(I_Mode),
      .I_Log_Len(I_Log_Len), .I_Rot_Amt(I_Rot_Amt), .I_Abort(I_Abort),
      .I_Issue_Rdy(I_Issue_Rdy), .I_WB_Valid(I_WB_Valid), .O_Req(O_Req),
      .O_Sel_Path(O_Sel_Path), .O_Busy(O_Busy), .O_Step(O_Step),
      .O_Done(O_Done), .O_Err(O_Err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   assign I_WB_Valid = wb_man | wb_auto_val;

   task automatic chk(input string tag, input int obs, input int want);
      total++;
      if (obs != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, want);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         if (O_Req && !req_prev) begin
            if (sb.size() == 0) chk("sb_underflow_req", sb.size(), 1);
            else begin
               e = sb.pop_front();
               chk("issue_kind", 0, int'(e.is_done));
               chk("sel_path", int'(O_Sel_Path), e.sel);
               chk("issue_step", int'(O_Step), e.step);
            end
         end
         if (O_Done) begin
            if (sb.size() == 0) chk("sb_underflow_done", sb.size(), 1);
            else begin
               e = sb.pop_front();
               chk("done_kind", 1, int'(e.is_done));
               chk("done_step", int'(O_Step), e.step);
               if (e.cyc >= 0) chk("done_cycle", cyc - start_cyc, e.cyc);
            end
         end
      end
      wb_auto_val = auto_wb && req_prev && !O_Req;
      req_prev    = O_Req;
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic push_reduce(input int len, input bit timed);
      exp_t e;
      int   cl;
      cl = (len > 4) ? 4 : len;
      for (int i = 0; i < cl; i++) begin
         e.is_done = 1'b0; e.sel = 16 + (1 << (cl - 1 - i)); e.step = i; e.cyc = -1;
         sb.push_back(e);
      end
      e.is_done = 1'b1; e.sel = 0; e.step = cl; e.cyc = timed ? 2 * cl + 1 : -1;
      sb.push_back(e);
   endtask

   task automatic push_issue(input int sel, input int step);
      exp_t e;
      e.is_done = 1'b0; e.sel = sel; e.step = step; e.cyc = -1;
      sb.push_back(e);
   endtask

   task automatic start_seq(input logic [2:0] len, input logic mode, input logic [3:0] amt);
      I_Log_Len = len; I_Mode = mode; I_Rot_Amt = amt; I_Start = 1'b1;
      start_cyc = cyc;
      tick();
      I_Start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((O_Busy || sb.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) chk("timeout_pending", sb.size() + int'(O_Busy), 0);
      sb.delete();
   endtask

   initial begin
      repeat (3) tick();
      chk("reset_outputs", int'({O_Req, O_Sel_Path, O_Busy, O_Step, O_Done, O_Err}), 0);
      reset = 1'b1;
      tick();

      // Full 16-lane reduce, ready always high, writeback one cycle after issue
      I_Issue_Rdy = 1'b1; auto_wb = 1'b1;
      push_reduce(4, 1); start_seq(3'd4, 1'b0, 4'd0); wait_idle(60);
      chk("idle_after_reduce4", int'(O_Busy), 0);

      push_reduce(0, 1); start_seq(3'd0, 1'b0, 4'd0); wait_idle(60);
      push_reduce(7, 1); start_seq(3'd7, 1'b0, 4'd0); wait_idle(60);
      push_reduce(2, 1); start_seq(3'd2, 1'b0, 4'd0); wait_idle(60);

      // Issue stall, then a stray writeback while still in ISSUE
      I_Issue_Rdy = 1'b0; auto_wb = 1'b0;
      push_reduce(4, 0); start_seq(3'd4, 1'b0, 4'd0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_req", int'(O_Req), 1);
         chk("stall_sel", int'(O_Sel_Path), 'h18);
         tick();
      end
      wb_man = 1'b1; tick(); wb_man = 1'b0;
      chk("stray_wb_err", int'(O_Err), 1);
      chk("stray_wb_req", int'(O_Req), 1);
      chk("stray_wb_sel", int'(O_Sel_Path), 'h18);
      chk("stray_wb_step", int'(O_Step), 0);
      I_Issue_Rdy = 1'b1; auto_wb = 1'b1;
      wait_idle(60);
      chk("err_sticky", int'(O_Err), 1);
      push_reduce(1, 1); start_seq(3'd1, 1'b0, 4'd0);
      chk("err_cleared", int'(O_Err), 0);
      wait_idle(60);

      // Abort together with writeback in WAIT of step 1
      auto_wb = 1'b0;
      push_issue('h18, 0); push_issue('h14, 1);
      start_seq(3'd4, 1'b0, 4'd0);
      tick(); wb_man = 1'b1;
      tick(); wb_man = 1'b0;
      tick();
      chk("abort_pre_step", int'(O_Step), 1);
      wb_man = 1'b1; I_Abort = 1'b1;
      tick(); wb_man = 1'b0; I_Abort = 1'b0;
      chk("abort_busy", int'(O_Busy), 0);
      chk("abort_req_sel", int'({O_Req, O_Sel_Path}), 0);
      chk("abort_no_done", int'(O_Done), 0);
      chk("abort_no_err", int'(O_Err), 0);
      I_Start = 1'b1; I_Abort = 1'b1; I_Log_Len = 3'd4;
      tick(); I_Start = 1'b0; I_Abort = 1'b0;
      chk("start_abort_idle", int'({O_Busy, O_Req}), 0);
      tick();
      chk("abort_sb_left", sb.size(), 0);
      sb.delete();

      // Reset held low for two cycles in WAIT
      push_issue('h18, 0);
      start_seq(3'd4, 1'b0, 4'd0);
      tick();
      chk("pre_reset_busy", int'(O_Busy), 1);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("reset_mid_outputs", int'({O_Req, O_Sel_Path, O_Busy, O_Step, O_Done, O_Err}), 0);
      end
      reset = 1'b1;
      repeat (3) tick();
      chk("reset_mid_idle", int'({O_Busy, O_Done}), 0);
      chk("reset_sb_left", sb.size(), 0);
      sb.delete();

      // Rotate stimulus; reduces over 3 levels when the feature is compiled out
      auto_wb = 1'b1;
`ifdef LANE_PATH_SEQ_ROTATE_EN
      begin
         exp_t e;
         push_issue('h15, 0);
         e.is_done = 1'b1; e.sel = 0; e.step = 1; e.cyc = 3;
         sb.push_back(e);
      end
`else
      push_reduce(3, 1);
`endif
      start_seq(3'd3, 1'b1, 4'd5);
      wait_idle(60);
      chk("final_idle", int'(O_Busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
